param_datapath: RTL

//   Parametrised register-file + ALU datapath with a valid/ready command interface.

---
 rtl/param_datapath.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/param_datapath.sv
// Register file + ALU datapath with a valid/ready command port, a 1-entry execute stage
// and an iterative shift-add multiplier that stalls the command port while it runs.
module param_datapath #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 16,
  parameter int OUT_W  = 7,
  parameter int MUL_EN = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] InPort,
  input  logic              InSel,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [2:0]        Op,
  input  logic              Wen,
  input  logic [AW-1:0]     WA,
  input  logic [AW-1:0]     RAA,
  input  logic [AW-1:0]     RAB,
  output logic [OUT_W-1:0]  OutPort,
  output logic              OutValid,
  output logic              Flag,
  output logic              Busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              ex_valid_q, ex_valid_d;
  logic [2:0]        ex_op_q, ex_op_d;
  logic              ex_wen_q, ex_wen_d;
  logic [AW-1:0]     ex_wa_q, ex_wa_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_port_q, out_port_d;
  logic              out_valid_q, out_valid_d;
  logic              flag_q, flag_d;

  logic [DATA_W-1:0] rf_rd [NREGS];
  logic [DATA_W-1:0] wb_result;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic              accept, is_mul_cmd;
  logic              ex_done, ex_nop, ex_produces, wb_we;

  assign CmdReady   = ~rst & (state_q == S_IDLE);
  assign accept     = CmdValid & CmdReady;
  assign is_mul_cmd = (MUL_EN != 0) && (Op == OP_MUL);

  // The execute stage completes only once the multiplier (if any) has finished.
  assign ex_done     = ex_valid_q & (state_q == S_IDLE);
  assign ex_nop      = (ex_op_q == OP_MUL) && (MUL_EN == 0);
  assign ex_produces = ex_done & (ex_op_q != OP_CMP) & ~ex_nop;
  assign wb_we       = ex_produces & ex_wen_q;

  always_comb begin
    wb_result = '0;
    case (ex_op_q)
      OP_ADD:  wb_result = ex_a_q + ex_b_q;
      OP_SUB:  wb_result = ex_a_q - ex_b_q;
      OP_AND:  wb_result = ex_a_q & ex_b_q;
      OP_MOV:  wb_result = ex_a_q;
      OP_OR:   wb_result = ex_a_q | ex_b_q;
      OP_XOR:  wb_result = ex_a_q ^ ex_b_q;
      OP_MUL:  wb_result = acc_q;
      default: wb_result = '0;
    endcase
  end

  // Bypass the result being written this edge so back-to-back readers see it.
  assign opnd_a = InSel ? InPort :
                  ((wb_we && ex_wa_q == RAA) ? wb_result : rf_rd[RAA]);
  assign opnd_b = (wb_we && ex_wa_q == RAB) ? wb_result : rf_rd[RAB];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
    logic [DATA_W-1:0] word_q, word_d;
    assign word_d    = (wb_we && ex_wa_q == AW'(gi)) ? wb_result : word_q;
    assign rf_rd[gi] = word_q;
    always_ff @(posedge clk) begin
      if (rst) word_q <= '0;
      else     word_q <= word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ex_valid_d  = ex_valid_q;
    ex_op_d     = ex_op_q;
    ex_wen_d    = ex_wen_q;
    ex_wa_d     = ex_wa_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_port_d  = out_port_q;
    out_valid_d = ex_produces;
    flag_d      = flag_q;

    if (state_q == S_IDLE) begin
      ex_valid_d = accept;
      if (accept) begin
        ex_op_d  = Op;
        ex_wen_d = Wen;
        ex_wa_d  = WA;
        ex_a_d   = opnd_a;
        ex_b_d   = opnd_b;
        acc_d    = '0;
        cnt_d    = '0;
        if (is_mul_cmd) state_d = S_MUL;
      end
    end else begin
      // Shift-add: multiplicand moves left, multiplier bits consumed LSB first.
      acc_d  = acc_q + (ex_b_q[0] ? ex_a_q : '0);
      ex_a_d = ex_a_q << 1;
      ex_b_d = ex_b_q >> 1;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_W - 1)) state_d = S_IDLE;
    end

    if (ex_produces) out_port_d = wb_result[OUT_W-1:0];

    if (ex_done && ex_op_q == OP_CMP)
      flag_d = (ex_a_q == ex_b_q);
    else if (ex_produces)
      flag_d = (ex_op_q == OP_MOV) ? 1'b0 : (wb_result == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ex_valid_q  <= 1'b0;
      ex_op_q     <= OP_ADD;
      ex_wen_q    <= 1'b0;
      ex_wa_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_wen_q    <= ex_wen_d;
      ex_wa_q     <= ex_wa_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      flag_q      <= flag_d;
    end
  end

  assign OutPort  = out_port_q;
  assign OutValid = out_valid_q;
  assign Flag     = flag_q;
  assign Busy     = (state_q == S_MUL);

endmodule
